// File: rtl/mem_pkg.sv
// Shared constants for the MIPS memory-access stage: bus widths, field positions and FSM states.
package mem_pkg;

   localparam int EXE_MEM_BUS_W = 154;
   localparam int MEM_WB_BUS_W  = 118;

   // lo_result down to pc occupy the same low bits on both buses
   localparam int PASS_W         = 86;
   localparam int EXE_RESULT_LSB = 86;
   localparam int STORE_DATA_LSB = 118;
   localparam int CTRL_LSB       = 150;

   localparam int RF_WDEST_LSB = 32;
   localparam int RF_WEN_BIT   = 37;
   localparam int MFC0_BIT     = 48;
   localparam int MFLO_BIT     = 50;
   localparam int MFHI_BIT     = 51;

   // mem_control = {inst_load, inst_store, ls_word, lb_sign}
   localparam int CTRL_LOAD  = 3;
   localparam int CTRL_STORE = 2;
   localparam int CTRL_WORD  = 1;
   localparam int CTRL_SIGN  = 0;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      HOLD      = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: passes whole words through, or selects one byte and sign/zero-extends it.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic        ls_word,
   input  logic        lb_sign,
   output logic [31:0] data
);

   logic signed [7:0]  byte_sel;
   logic signed [31:0] byte_sext;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
   end

   assign byte_sext = 32'(byte_sel);

   assign data = ls_word ? rdata
               : (lb_sign ? byte_sext : {24'd0, byte_sel});

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: issues stores once, waits one cycle for synchronous loads, drives MEM->WB.
// Optional forwarding path enabled by defining MEM_BYPASS_EN.
module mem_stage
   import mem_pkg::*;
(
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     MEM_valid,
   input  logic [EXE_MEM_BUS_W-1:0] EXE_MEM_bus_r,
   input  logic                     WB_allow_in,
   input  logic [31:0]              dm_rdata,
   output logic                     MEM_over,
   output logic [MEM_WB_BUS_W-1:0]  MEM_WB_bus,
   output logic [4:0]               MEM_wdest,
   output logic [31:0]              MEM_pc,
   output logic [31:0]              dm_addr,
   output logic [3:0]               dm_wen,
   output logic [31:0]              dm_wdata,
   output logic [31:0]              MEM_bypass_value,
   output logic                     MEM_bypass_valid
);

   logic [3:0]  mem_control;
   logic        inst_load, inst_store, ls_word, lb_sign;
   logic [31:0] store_data, exe_result, pc;
   logic [4:0]  rf_wdest;

   assign mem_control = EXE_MEM_bus_r[CTRL_LSB +: 4];
   assign inst_load   = mem_control[CTRL_LOAD];
   assign inst_store  = mem_control[CTRL_STORE];
   assign ls_word     = mem_control[CTRL_WORD];
   assign lb_sign     = mem_control[CTRL_SIGN];
   assign store_data  = EXE_MEM_bus_r[STORE_DATA_LSB +: 32];
   assign exe_result  = EXE_MEM_bus_r[EXE_RESULT_LSB +: 32];
   assign rf_wdest    = EXE_MEM_bus_r[RF_WDEST_LSB +: 5];
   assign pc          = EXE_MEM_bus_r[31:0];

   mem_state_e  state, state_nxt;
   logic [31:0] load_r;
   logic        store_fire, use_load_r;

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The RAM word is only guaranteed on dm_rdata during LOAD_WAIT; keep a copy for stalls.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         load_r <= '0;
      end else if (state == LOAD_WAIT) begin
         load_r <= dm_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (MEM_valid && inst_load)
               state_nxt = LOAD_WAIT;
            else if (MEM_valid && inst_store && !WB_allow_in)
               state_nxt = HOLD;
            else
               state_nxt = IDLE;
         end
         LOAD_WAIT: state_nxt = WB_allow_in ? IDLE : HOLD;
         HOLD:      state_nxt = WB_allow_in ? IDLE : HOLD;
         default:   state_nxt = IDLE;
      endcase
      if (!MEM_valid)
         state_nxt = IDLE;
   end

   // Writes are confined to IDLE so a stalled store never rewrites the RAM.
   always_comb begin
      MEM_over   = 1'b0;
      store_fire = 1'b0;
      use_load_r = 1'b0;
      case (state)
         IDLE: begin
            MEM_over   = MEM_valid && !inst_load;
            store_fire = MEM_valid && inst_store;
         end
         LOAD_WAIT: MEM_over = MEM_valid;
         HOLD: begin
            MEM_over   = MEM_valid;
            use_load_r = 1'b1;
         end
         default: MEM_over = 1'b0;
      endcase
   end

   assign dm_addr  = exe_result;
   assign dm_wen   = store_fire ? (ls_word ? 4'hF : (4'b0001 << exe_result[1:0])) : 4'h0;
   assign dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};

   logic [31:0] load_raw, load_fmt, mem_result;

   assign load_raw = use_load_r ? load_r : dm_rdata;

   mem_load_align u_align (
      .rdata   (load_raw),
      .addr    (exe_result[1:0]),
      .ls_word (ls_word),
      .lb_sign (lb_sign),
      .data    (load_fmt)
   );

   assign mem_result = inst_load ? load_fmt : exe_result;
   assign MEM_WB_bus = {mem_result, EXE_MEM_bus_r[PASS_W-1:0]};
   assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
   assign MEM_pc     = pc;

`ifdef MEM_BYPASS_EN
   // mfhi/mflo/mfc0 results are produced in write-back, so they cannot be forwarded from here.
   assign MEM_bypass_valid = MEM_over && EXE_MEM_bus_r[RF_WEN_BIT]
                          && !EXE_MEM_bus_r[MFHI_BIT] && !EXE_MEM_bus_r[MFLO_BIT]
                          && !EXE_MEM_bus_r[MFC0_BIT];
   assign MEM_bypass_value = mem_result;
`else
   assign MEM_bypass_valid = 1'b0;
   assign MEM_bypass_value = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         resetn, MEM_valid, WB_allow_in;
   logic [153:0] EXE_MEM_bus_r;
   logic [31:0]  dm_rdata;
   logic         MEM_over;
   logic [117:0] MEM_WB_bus;
   logic [4:0]   MEM_wdest;
   logic [31:0]  MEM_pc, dm_addr, dm_wdata, MEM_bypass_value;
   logic [3:0]   dm_wen;
   logic         MEM_bypass_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk              (clk),
      .resetn           (resetn),
      .MEM_valid        (MEM_valid),
      .EXE_MEM_bus_r    (EXE_MEM_bus_r),
      .WB_allow_in      (WB_allow_in),
      .dm_rdata         (dm_rdata),
      .MEM_over         (MEM_over),
      .MEM_WB_bus       (MEM_WB_bus),
      .MEM_wdest        (MEM_wdest),
      .MEM_pc           (MEM_pc),
      .dm_addr          (dm_addr),
      .dm_wen           (dm_wen),
      .dm_wdata         (dm_wdata),
      .MEM_bypass_value (MEM_bypass_value),
      .MEM_bypass_valid (MEM_bypass_valid)
   );

   // Synchronous-read RAM (1 KiB), plus a preload port and a read-data override for garbage injection
   logic [31:0] ram [0:255];
   logic [31:0] ram_q, pre_data, ovr_data;
   logic [7:0]  pre_idx;
   logic        pre_we, rd_ovr;

   always @(posedge clk) begin
      if (pre_we) ram[pre_idx] <= pre_data;
      for (int b = 0; b < 4; b++)
         if (dm_wen[b]) ram[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      ram_q <= ram[dm_addr[9:2]];
   end

   assign dm_rdata = rd_ovr ? ovr_data : ram_q;

   // Reference model: memory as plain bytes, instructions as abstract kinds
   typedef enum int {K_ALU, K_SW, K_SB, K_LW, K_LB, K_LBU} kind_e;
   logic [7:0] ref_mem [0:1023];

   function automatic logic [3:0] ctrl_of(input kind_e k);
      case (k)
         K_SW:    return 4'b0110;
         K_SB:    return 4'b0100;
         K_LW:    return 4'b1010;
         K_LB:    return 4'b1001;
         K_LBU:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int base = {22'd0, a[9:2], 2'b00};
      return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
   endfunction

   function automatic logic [31:0] ref_load(input kind_e k, input logic [31:0] a);
      logic [7:0] b = ref_mem[a[9:0]];
      if (k == K_LW) return ref_word(a);
      if (k == K_LB) return {{24{b[7]}}, b};
      return {24'd0, b};
   endfunction

   function automatic logic [3:0] ref_wen(input kind_e k, input logic [31:0] a);
      if (k == K_SW) return 4'hF;
      if (k == K_SB) return 4'(1 << a[1:0]);
      return 4'h0;
   endfunction

   task automatic ref_store(input kind_e k, input logic [31:0] a, input logic [31:0] d);
      if (k == K_SW)
         for (int i = 0; i < 4; i++) ref_mem[{22'd0, a[9:2], 2'b00} + i] = d[8*i +: 8];
      else if (k == K_SB)
         ref_mem[a[9:0]] = d[7:0];
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      pre_we = 1'b1; pre_idx = a[9:2]; pre_data = w;
      @(posedge clk); #1;
      pre_we = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[{22'd0, a[9:2], 2'b00} + i] = w[8*i +: 8];
   endtask

   // Runs one instruction to handoff; WB stalls for 'stall' cycles; loads optionally see garbage after capture
   task automatic run_instr(input kind_e k, input logic [31:0] a, input logic [31:0] d,
                            input logic [85:0] low, input int stall, input bit garbage);
      bit          is_load, is_store, done, exp_over, exp_bv;
      logic [31:0] exp_res, exp_bvalue;
      logic [3:0]  exp_wen;
      int          cyc;
      is_load  = (k == K_LW) || (k == K_LB) || (k == K_LBU);
      is_store = (k == K_SW) || (k == K_SB);
      exp_res  = is_load ? ref_load(k, a) : a;
      EXE_MEM_bus_r = {ctrl_of(k), d, a, low};
      MEM_valid = 1'b1;
      done = 0; cyc = 0;
      while (!done) begin
         WB_allow_in = (cyc >= stall);
         if (garbage && is_load && cyc >= 2) begin rd_ovr = 1'b1; ovr_data = $urandom; end
         @(negedge clk);
         exp_over = is_load ? (cyc >= 1) : 1'b1;
         exp_wen  = (cyc == 0) ? ref_wen(k, a) : 4'h0;
`ifdef MEM_BYPASS_EN
         exp_bv     = exp_over & low[37] & ~low[51] & ~low[50] & ~low[48];
         exp_bvalue = exp_res;
`else
         exp_bv     = 1'b0;
         exp_bvalue = 32'd0;
`endif
         n_checks++;
         if (MEM_over !== exp_over) begin n_fail++;
            $display("FAIL rnd_over k=%0d cyc=%0d: got %b expected %b", k, cyc, MEM_over, exp_over); end
         n_checks++;
         if (dm_wen !== exp_wen) begin n_fail++;
            $display("FAIL rnd_wen k=%0d cyc=%0d: got %h expected %h", k, cyc, dm_wen, exp_wen); end
         if (exp_wen != 4'h0) begin
            n_checks++;
            if (dm_wdata !== ((k == K_SW) ? d : {4{d[7:0]}})) begin n_fail++;
               $display("FAIL rnd_wdata k=%0d: got %h data %h", k, dm_wdata, d); end
         end
         if (exp_over) begin
            n_checks++;
            if (MEM_WB_bus[117:86] !== exp_res) begin n_fail++;
               $display("FAIL rnd_result k=%0d addr=%h cyc=%0d: got %h expected %h", k, a, cyc, MEM_WB_bus[117:86], exp_res); end
            n_checks++;
            if (MEM_bypass_value !== exp_bvalue) begin n_fail++;
               $display("FAIL rnd_byp_value: got %h expected %h", MEM_bypass_value, exp_bvalue); end
         end
         n_checks++;
         if (MEM_bypass_valid !== exp_bv) begin n_fail++;
            $display("FAIL rnd_byp_valid: got %b expected %b", MEM_bypass_valid, exp_bv); end
         n_checks++;
         if (MEM_WB_bus[85:0] !== low || MEM_pc !== low[31:0] || MEM_wdest !== low[36:32] || dm_addr !== a) begin
            n_fail++;
            $display("FAIL rnd_passthru: bus %h pc %h wdest %h addr %h expected %h %h %h %h",
                     MEM_WB_bus[85:0], MEM_pc, MEM_wdest, dm_addr, low, low[31:0], low[36:32], a);
         end
         @(posedge clk); #1;
         if (exp_over && WB_allow_in) done = 1;
         cyc++;
         if (!done && cyc > 20) begin
            n_checks++; n_fail++;
            $display("FAIL rnd_timeout k=%0d: no handoff after %0d cycles, required within %0d", k, cyc, stall + 1);
            done = 1;
         end
      end
      rd_ovr = 1'b0;
      ref_store(k, a, d);
   endtask

   task automatic test_reset();
      resetn = 1'b1; MEM_valid = 1'b0; WB_allow_in = 1'b1;
      rd_ovr = 1'b0; ovr_data = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
      EXE_MEM_bus_r = {4'b0110, 32'h1111_2222, 32'h0000_0100, 86'd0};
      EXE_MEM_bus_r[37:32] = 6'b1_00101;
      for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
      @(negedge clk);
      n_checks++;
      if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %b expected 0", MEM_over); end
      n_checks++;
      if (dm_wen !== 4'h0) begin n_fail++; $display("FAIL reset_wen: got %h expected 0", dm_wen); end
      n_checks++;
      if (MEM_bypass_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byp: got %b expected 0", MEM_bypass_valid); end
      n_checks++;
      if (MEM_wdest !== 5'd0) begin n_fail++; $display("FAIL reset_wdest: got %h expected 0", MEM_wdest); end
      @(posedge clk); #1;
      resetn = 1'b0;
   endtask

   task automatic test_sw();
      EXE_MEM_bus_r = {4'b0110, 32'hDEAD_BEEF, 32'h0000_0100, 86'h0040_0000};
      MEM_valid = 1'b1; WB_allow_in = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dm_wen !== 4'hF || MEM_over !== 1'b1 || dm_wdata !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL sw_issue: wen %h over %b wdata %h expected f 1 deadbeef", dm_wen, MEM_over, dm_wdata); end
      @(posedge clk); #1;
      MEM_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dm_wen !== 4'h0) begin n_fail++; $display("FAIL sw_once: got %h expected 0", dm_wen); end
      @(posedge clk); #1;
      ref_store(K_SW, 32'h100, 32'hDEAD_BEEF);
      run_instr(K_LW, 32'h100, 32'd0, 86'h3, 0, 0);
      MEM_valid = 1'b0;
   endtask

   task automatic test_sb_stall();
      EXE_MEM_bus_r = {4'b0100, 32'h0000_00A5, 32'h0000_0103, 86'h0040_0004};
      MEM_valid = 1'b1; WB_allow_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) WB_allow_in = 1'b1;
         @(negedge clk);
         n_checks++;
         if (dm_wen !== ((c == 0) ? 4'b1000 : 4'b0000) || MEM_over !== 1'b1) begin n_fail++;
            $display("FAIL sb_stall cyc=%0d: wen %b over %b expected %b 1", c, dm_wen, MEM_over, (c == 0) ? 4'b1000 : 4'b0000); end
         if (c == 0) begin
            n_checks++;
            if (dm_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", dm_wdata); end
         end
         @(posedge clk); #1;
      end
      MEM_valid = 1'b0;
      ref_store(K_SB, 32'h103, 32'hA5);
      run_instr(K_LW, 32'h100, 32'd0, 86'h5, 1, 0);
      MEM_valid = 1'b0;
   endtask

   task automatic test_lb();
      logic [31:0] exp_v [2];
      exp_v[0] = 32'hFFFF_FFF4; exp_v[1] = 32'h0000_00F4;
      preload(32'h100, 32'h12F4_5678);
      WB_allow_in = 1'b1; MEM_valid = 1'b1;
      for (int j = 0; j < 2; j++) begin
         EXE_MEM_bus_r = {(j == 0) ? 4'b1001 : 4'b1000, 32'd0, 32'h0000_0102, 86'h0040_0008};
         @(negedge clk);
         n_checks++;
         if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL lb_entry%0d: over %b expected 0", j, MEM_over); end
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (MEM_over !== 1'b1 || MEM_WB_bus[117:86] !== exp_v[j]) begin n_fail++;
            $display("FAIL lb_result%0d: over %b result %h expected 1 %h", j, MEM_over, MEM_WB_bus[117:86], exp_v[j]); end
         @(posedge clk); #1;
      end
      MEM_valid = 1'b0;
   endtask

   task automatic test_lw_stall();
      preload(32'h200, 32'hCAFE_F00D);
      EXE_MEM_bus_r = {4'b1010, 32'd0, 32'h0000_0201, 86'h0040_000C};
      MEM_valid = 1'b1; WB_allow_in = 1'b0;
      @(posedge clk); #1;
      for (int c = 1; c < 4; c++) begin
         if (c >= 2) begin rd_ovr = 1'b1; ovr_data = $urandom; end
         if (c == 3) WB_allow_in = 1'b1;
         @(negedge clk);
         n_checks++;
         if (MEM_over !== 1'b1 || MEM_WB_bus[117:86] !== 32'hCAFE_F00D) begin n_fail++;
            $display("FAIL lw_stall cyc=%0d: over %b result %h expected 1 cafef00d", c, MEM_over, MEM_WB_bus[117:86]); end
         @(posedge clk); #1;
      end
      MEM_valid = 1'b0; rd_ovr = 1'b0;
   endtask

   task automatic test_reset_in_load();
      EXE_MEM_bus_r = {4'b1010, 32'd0, 32'h0000_0100, 86'h0040_0010};
      MEM_valid = 1'b1; WB_allow_in = 1'b0;
      @(posedge clk); #3;
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (MEM_over !== 1'b0 || dm_wen !== 4'h0) begin n_fail++;
         $display("FAIL reset_in_load: over %b wen %h expected 0 0", MEM_over, dm_wen); end
      @(posedge clk); #1;
      resetn = 1'b0; MEM_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush_hold();
      EXE_MEM_bus_r = {4'b0100, 32'h0000_003C, 32'h0000_0300, 86'h0040_0014};
      MEM_valid = 1'b1; WB_allow_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dm_wen !== 4'b0001) begin n_fail++; $display("FAIL flush_sb_wen: got %b expected 0001", dm_wen); end
      ref_store(K_SB, 32'h300, 32'h3C);
      @(posedge clk); #1;
      MEM_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (MEM_over !== 1'b0 || dm_wen !== 4'h0) begin n_fail++;
         $display("FAIL flush_drop: over %b wen %h expected 0 0", MEM_over, dm_wen); end
      @(posedge clk); #1;
      EXE_MEM_bus_r = {4'b1010, 32'd0, 32'h0000_0300, 86'h0040_0018};
      MEM_valid = 1'b1; WB_allow_in = 1'b1;
      @(negedge clk);
      n_checks++;
      if (MEM_over !== 1'b0) begin n_fail++; $display("FAIL flush_idle: over %b expected 0", MEM_over); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (MEM_WB_bus[117:86] !== ref_word(32'h300)) begin n_fail++;
         $display("FAIL flush_load: got %h expected %h", MEM_WB_bus[117:86], ref_word(32'h300)); end
      @(posedge clk); #1;
      MEM_valid = 1'b0;
   endtask

   task automatic test_bypass();
      logic [85:0] low;
      logic        exp_v [2];
      logic [31:0] exp_val;
`ifdef MEM_BYPASS_EN
      exp_v[0] = 1'b1; exp_v[1] = 1'b0; exp_val = 32'h7;
`else
      exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_val = 32'h0;
`endif
      WB_allow_in = 1'b1; MEM_valid = 1'b1;
      for (int j = 0; j < 2; j++) begin
         low = 86'h0040_0020;
         low[37] = 1'b1; low[36:32] = 5'd5; low[48] = (j == 1);
         EXE_MEM_bus_r = {4'b0000, 32'd0, 32'h0000_0007, low};
         @(negedge clk);
         n_checks++;
         if (MEM_bypass_valid !== exp_v[j] || MEM_bypass_value !== exp_val || MEM_wdest !== 5'd5) begin n_fail++;
            $display("FAIL bypass%0d: valid %b value %h wdest %0d expected %b %h 5", j, MEM_bypass_valid, MEM_bypass_value, MEM_wdest, exp_v[j], exp_val); end
         @(posedge clk); #1;
      end
      MEM_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [95:0] r;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            MEM_valid = 1'b0; WB_allow_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (MEM_over !== 1'b0 || dm_wen !== 4'h0 || MEM_bypass_valid !== 1'b0) begin n_fail++;
               $display("FAIL bubble: over %b wen %h byp %b expected 0 0 0", MEM_over, dm_wen, MEM_bypass_valid); end
            @(posedge clk); #1;
         end
         r = {$urandom, $urandom, $urandom};
         run_instr(kind_e'($urandom_range(0, 5)), 32'($urandom_range(0, 1023)), $urandom,
                   r[85:0], int'($urandom_range(0, 2)), 1'b1);
      end
      MEM_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required $finish before it");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_sw();
      test_sb_stall();
      test_lb();
      test_lw_stall();
      test_reset_in_load();
      test_flush_hold();
      test_bypass();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting between the execute stage and write-back. It unpacks the 154-bit EXE->MEM bus and drives the data RAM. Stores issue exactly once; loads wait one cycle for the synchronous-read RAM and are byte-aligned and extended. It emits the 118-bit MEM->WB bus and reports completion with a stall-aware `MEM_over` handshake.

## Interface
- No parameters; all widths are fixed constants in `mem_pkg`.
- `clk`  in  1  pipeline clock. Reset is asynchronous and active-high.
- `resetn`  in  1  reset; the port keeps the codebase name, but the polarity is fixed: asserted high, asynchronous.
- `MEM_valid`  in  1  MEM stage holds a live instruction.
- `EXE_MEM_bus_r`  in  154  registered bus, MSB first: `mem_control[3:0]`, `store_data[31:0]`, `exe_result[31:0]`, `lo_result[31:0]`, `hi_write`, `lo_write`, `mfhi`, `mflo`, `mtc0`, `mfc0`, `cp0r_addr[7:0]`, `syscall`, `eret`, `rf_wen`, `rf_wdest[4:0]`, `pc[31:0]`.
- `WB_allow_in`  in  1  write-back accepts the bus this cycle.
- `dm_rdata`  in  32  RAM read data, valid one cycle after `dm_addr`.
- `MEM_over`  out  1  result valid on `MEM_WB_bus`.
- `MEM_WB_bus`  out  118  bus, MSB first: `mem_result[31:0]`, `lo_result`, `hi_write`, `lo_write`, `mfhi`, `mflo`, `mtc0`, `mfc0`, `cp0r_addr`, `syscall`, `eret`, `rf_wen`, `rf_wdest`, `pc`.
- `MEM_wdest`  out  5  `rf_wdest` masked by `MEM_valid`.
- `MEM_pc`  out  32  `pc`, for display.
- `dm_addr`  out  32  equals `exe_result`.
- `dm_wen`  out  4  byte write enables.
- `dm_wdata`  out  32  store data.
- `MEM_bypass_value`  out  32  forwarding value.
- `MEM_bypass_valid`  out  1  forwarding value usable.

## Operation
- `mem_control` bits: `{inst_load, inst_store, ls_word, lb_sign}`. Load and store are mutually exclusive.
- FSM states:
  - `IDLE`
  - `LOAD_WAIT`
  - `HOLD`
- Transitions from `IDLE`:
  - `MEM_valid & inst_load` -> `LOAD_WAIT`.
  - `MEM_valid & inst_store & ~WB_allow_in` -> `HOLD`.
  - All other cases stay in `IDLE`.
- Transitions from the other states:
  - `LOAD_WAIT`: capture `dm_rdata` into `load_r`. Go to `IDLE` if `WB_allow_in`, otherwise to `HOLD`.
  - `HOLD`: go to `IDLE` on `WB_allow_in`.
  - `~MEM_valid` (flush) in any state forces `IDLE` on the next edge.
- `MEM_over`:
  - In `IDLE`: `MEM_valid & ~inst_load`.
  - In `LOAD_WAIT` and `HOLD`: `MEM_valid`.
- Store enables, asserted only in `IDLE` with `MEM_valid & inst_store`, so each store writes exactly once regardless of stalls:
  - `sw`: `dm_wen=4'b1111`, `dm_wdata=store_data`.
  - `sb`: `dm_wen` is one-hot at `addr[1:0]`, and `dm_wdata` is `store_data[7:0]` replicated 4×.
- Load data source: raw `dm_rdata` in `LOAD_WAIT`, `load_r` in `HOLD`.
- Load formatting:
  - Word load: the data unchanged.
  - Byte load: byte `addr[1:0]`, sign-extended when `lb_sign`, zero-extended otherwise.
- `mem_result` is the formatted load data for loads, `exe_result` otherwise.
- All other fields pass straight through.

## Timing
- Reset: state `IDLE`, `load_r=0`. `MEM_over`, `dm_wen` and `MEM_bypass_valid` read 0 while `MEM_valid=0`.
- Non-load instructions: 0-cycle latency; `MEM_over` is combinational in the cycle `MEM_valid` rises.
- Loads: `MEM_over` asserts one cycle after entry.
- Unaligned `sw`/`lw` addresses: no exception; the address is used with `addr[1:0]` ignored.
- Reset during `LOAD_WAIT` or `HOLD`: return to `IDLE` and issue no RAM write.
- Back-to-back instructions: the next instruction arrives in `IDLE` the cycle after handoff, which is `MEM_over & WB_allow_in`.

## Configuration
- Macro: `MEM_BYPASS_EN`.
- Defined:
  - `MEM_bypass_valid = MEM_over & rf_wen & ~mfhi & ~mflo & ~mfc0`.
  - `MEM_bypass_value = mem_result`.
- Undefined: both bypass outputs are tied to 0, and the hazard unit stalls instead of forwarding.

## Structure
- `mem_pkg` holds:
  - bus widths (EXE->MEM 154, MEM->WB 118);
  - `mem_control` bit indices;
  - the FSM state enum.
- Sub-module `mem_load_align`: combinational byte select and extend, with inputs `rdata`, `addr[1:0]`, `ls_word` and `lb_sign`.

## Test plan
- `sw`, addr `0x100`, data `0xDEADBEEF`, `WB_allow_in=1` -> `dm_wen=4'hF` for exactly 1 cycle, `MEM_over=1` the same cycle.
- `sb`, addr `0x103`, data `0x000000A5`, `WB_allow_in` held low 3 cycles -> `dm_wen=4'b1000` only in the first cycle, `dm_wdata=0xA5A5A5A5`, FSM in `HOLD` until release.
- `lb` signed, addr `0x102`, RAM word `0x12F45678` -> `MEM_over` 1 cycle later, `mem_result=0xFFFFFFF4`. Repeat as `lbu` -> `0x000000F4`.
- `lw` with a 2-cycle stall while `dm_rdata` changes to garbage -> `mem_result` keeps the captured word.
- Async reset asserted in `LOAD_WAIT` -> state `IDLE`, `MEM_over=0`, no write. Flush (`MEM_valid` drop) in `HOLD` -> `IDLE` next edge.
- `MEM_BYPASS_EN` defined, `addu` to `$5` = `0x7` -> `MEM_bypass_valid=1`, value `0x7`. With an `mfc0` instead -> valid 0. Macro undefined -> both outputs 0.
